// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor: computes diff = a - b one bit per clock, LSB first,
// through a single subtract-with-borrow cell. A controlling FSM starts it with
// a start request and sees busy while the bits are shifting. A one-cycle done
// pulse marks the cycle in which the result first appears.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high, highest priority
//   start  in   request; only looked at while idle
//   a      in   WIDTH-bit minuend, captured on the accepted start edge
//   b      in   WIDTH-bit subtrahend, captured on the accepted start edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse; diff/borrow are valid on this cycle
//   diff   out  WIDTH-bit (a - b) mod 2^WIDTH, held until the next result
//   borrow out  final borrow-out (a < b unsigned)
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // One subtract-with-borrow cell; returns {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bin);
        logic d_bit;
        logic b_out;
        d_bit = x ^ y ^ bin;
        b_out = (~x & y) | (~(x ^ y) & bin);
        return {b_out, d_bit};
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             br_q;
    logic             br_d;
    logic             d_bit_d;
    logic [CNT_W-1:0] cnt_q;
    logic             last_d;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    // Datapath for the current bit: difference, next borrow and the
    // partially built result with the new bit entering at the MSB.
    always_comb begin
        {br_d, d_bit_d} = sub_cell(a_sh_q[0], b_sh_q[0], br_q);
        res_d           = {d_bit_d, res_q[WIDTH-1:1]};
        last_d          = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM plus shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        res_q   <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
                    res_q  <= res_d;
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_d) begin
                        // Publish the finished result only here so partial
                        // results never reach the outputs.
                        diff_q   <= res_d;
                        borrow_q <= br_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16.
// Expected results are pushed to a queue when an operation is started and
// popped when the matching done pulse is observed.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, busy8, done8, borrow8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, busy16, done16, borrow16;
    logic [15:0] a16, b16, diff16;

    int errors = 0;
    int checks = 0;
    int done_cnt8 = 0;
    int overlap_cnt = 0;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16)
    );

    // Background monitors: done pulse count and busy/done overlap.
    always @(negedge clk) begin
        if (done8 === 1'b1) done_cnt8 <= done_cnt8 + 1;
        if ((busy8 === 1'b1 && done8 === 1'b1) || (busy16 === 1'b1 && done16 === 1'b1))
            overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Start one 8-bit operation and wait (bounded) for its done pulse.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output logic br,
                          output int lat, output int bcnt, output bit ok);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back({1'b0, a} - {1'b0, b});
        @(negedge clk);
        start8 = 1'b0;
        lat = 1; bcnt = 0; ok = 1'b0; d = 8'h00; br = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (done8 === 1'b1) begin
                ok = 1'b1; d = diff8; br = borrow8;
            end else begin
                if (busy8 === 1'b1) bcnt++;
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] d, output logic br, output bit ok);
        @(negedge clk);
        a16 = a; b16 = b; start16 = 1'b1;
        q16.push_back({1'b0, a} - {1'b0, b});
        @(negedge clk);
        start16 = 1'b0;
        ok = 1'b0; d = 16'h0000; br = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (done16 === 1'b1) begin
                ok = 1'b1; d = diff16; br = borrow16;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start8 = 1'b1; start16 = 1'b1;
        a8 = 8'h55; b8 = 8'h11; a16 = 16'h1234; b16 = 16'h0001;
        repeat (3) @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
        checks++; if (diff8 !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h expected 00", diff8); end
        checks++; if (borrow8 !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", borrow8); end
        checks++; if (busy16 !== 1'b0 || diff16 !== 16'h0000) begin
            errors++; $display("FAIL reset_dut16: busy=%b diff=%h expected 0/0000", busy16, diff16);
        end
        start8 = 1'b0; start16 = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_start_lost: busy got %b expected 0", busy8); end
    endtask

    task automatic test_basic;
        logic [7:0] ta [0:3] = '{8'd9, 8'd5, 8'd0, 8'hFF};
        logic [7:0] tb [0:3] = '{8'd5, 8'd9, 8'd1, 8'hFF};
        logic [7:0] d; logic br; int lat; int bcnt; bit ok; logic [8:0] exp;
        for (int i = 0; i < 4; i++) begin
            do_op8(ta[i], tb[i], d, br, lat, bcnt, ok);
            exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
            checks++;
            if (!ok) begin
                errors++; $display("FAIL basic_timeout[%0d]: no done pulse within bound", i);
            end else begin
                checks++; if (d !== exp[7:0]) begin errors++; $display("FAIL basic_diff[%0d]: got %h expected %h", i, d, exp[7:0]); end
                checks++; if (br !== exp[8]) begin errors++; $display("FAIL basic_borrow[%0d]: got %b expected %b", i, br, exp[8]); end
                checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected 9", i, lat); end
                checks++; if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles[%0d]: got %0d expected 8", i, bcnt); end
            end
            @(negedge clk);
            checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse[%0d]: got %b expected 0", i, done8); end
            checks++; if (diff8 !== exp[7:0]) begin errors++; $display("FAIL basic_hold[%0d]: got %h expected %h", i, diff8, exp[7:0]); end
        end
    endtask

    task automatic test_ignore_start;
        int dc0; bit seen; logic [8:0] exp; logic [7:0] d; logic br; int lat; int bcnt; bit ok;
        @(negedge clk);
        a8 = 8'h30; b8 = 8'h10; start8 = 1'b1;
        q8.push_back({1'b0, 8'h30} - {1'b0, 8'h10});
        dc0 = done_cnt8;
        seen = 1'b0;
        // Keep start high with other operands through SHIFT and DONE.
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            a8 = 8'h01; b8 = 8'h02;
            if (done8 === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
        checks++; if (!seen) begin errors++; $display("FAIL ignore_timeout: no done pulse within bound"); end
        checks++; if (done_cnt8 - dc0 !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt8 - dc0); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %b expected 0", busy8); end
        checks++; if (diff8 !== exp[7:0]) begin errors++; $display("FAIL ignore_diff: got %h expected %h", diff8, exp[7:0]); end
        checks++; if (borrow8 !== exp[8]) begin errors++; $display("FAIL ignore_borrow: got %b expected %b", borrow8, exp[8]); end
        do_op8(8'h01, 8'h02, d, br, lat, bcnt, ok);
        exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
        checks++; if (!ok || d !== exp[7:0] || br !== exp[8]) begin
            errors++; $display("FAIL ignore_next: got ok=%b %b/%h expected 1 %b/%h", ok, br, d, exp[8], exp[7:0]);
        end
    endtask

    task automatic test_reset_mid;
        int dc0; logic [8:0] exp; logic [7:0] d; logic br; int lat; int bcnt; bit ok;
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy8); end
        rst = 1'b1;
        dc0 = done_cnt8;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: busy=%b done=%b expected 0/0", busy8, done8);
        end
        checks++; if (diff8 !== 8'h00 || borrow8 !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: diff=%h borrow=%b expected 00/0", diff8, borrow8);
        end
        repeat (15) @(negedge clk);
        checks++; if (done_cnt8 - dc0 !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt8 - dc0); end
        do_op8(8'h7A, 8'h3C, d, br, lat, bcnt, ok);
        exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
        checks++; if (!ok || d !== exp[7:0] || br !== exp[8]) begin
            errors++; $display("FAIL midrst_fresh: got ok=%b %b/%h expected 1 %b/%h", ok, br, d, exp[8], exp[7:0]);
        end
    endtask

    task automatic test_back_to_back;
        int last_done; int ndone; int hold_err; bit have; logic [7:0] held;
        logic [7:0] ra, rb; logic [8:0] exp;
        last_done = -1; ndone = 0; hold_err = 0; have = 1'b0; held = 8'h00;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                ndone++;
                exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
                checks++; if (diff8 !== exp[7:0] || borrow8 !== exp[8]) begin
                    errors++; $display("FAIL b2b_result@%0d: got %b/%h expected %b/%h", c, borrow8, diff8, exp[8], exp[7:0]);
                end
                if (last_done >= 0) begin
                    checks++; if (c - last_done !== 10) begin
                        errors++; $display("FAIL b2b_period: got %0d expected 10", c - last_done);
                    end
                end
                last_done = c; held = diff8; have = 1'b1;
            end else if (have && diff8 !== held) begin
                hold_err++;
            end
            ra = 8'($urandom); rb = 8'($urandom);
            a8 = ra; b8 = rb; start8 = (c < 49);
            if (c % 10 == 0) q8.push_back({1'b0, ra} - {1'b0, rb});
        end
        checks++; if (ndone !== 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", ndone); end
        checks++; if (hold_err !== 0) begin errors++; $display("FAIL b2b_hold: got %0d changes expected 0", hold_err); end
        checks++; if (q8.size() !== 0) begin errors++; $display("FAIL b2b_queue: got %0d left expected 0", q8.size()); end
        q8.delete();
    endtask

    task automatic test_random;
        logic [7:0] d8; logic [15:0] d16; logic br; int lat; int bcnt; bit ok;
        logic [8:0] e8; logic [16:0] e16;
        for (int i = 0; i < 1000; i++) begin
            do_op8(8'($urandom), 8'($urandom), d8, br, lat, bcnt, ok);
            e8 = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
            checks++; if (!ok || d8 !== e8[7:0] || br !== e8[8]) begin
                errors++; $display("FAIL rand8[%0d]: got ok=%b %b/%h expected 1 %b/%h", i, ok, br, d8, e8[8], e8[7:0]);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            do_op16(16'($urandom), 16'($urandom), d16, br, ok);
            e16 = (q16.size() > 0) ? q16.pop_front() : 17'h1FFFF;
            checks++; if (!ok || d16 !== e16[15:0] || br !== e16[16]) begin
                errors++; $display("FAIL rand16[%0d]: got ok=%b %b/%h expected 1 %b/%h", i, ok, br, d16, e16[16], e16[15:0]);
            end
        end
    endtask

    task automatic test_no_overlap;
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL busy_done_overlap: got %0d cycles expected 0", overlap_cnt); end
    endtask

    initial begin
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a16 = 16'h0000; b16 = 16'h0000;
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_no_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
